// File: rtl/dpram_byte_reader.sv
// Read-side engine of the shared dual-port word buffer: tracks rd_ptr against the
// writer's pointer, fetches words over the combinational RAM port and streams bytes out.
`timescale 1ns/1ps
module dpram_byte_reader #(
   parameter int unsigned aw = 8,
   parameter int unsigned dw = 32
) (
   input  logic          rclk,
   input  logic          rrst,
   input  logic [aw:0]   wr_ptr,
   output logic [aw-1:0] raddr,
   input  logic [dw-1:0] dout,
   input  logic          flush,
   output logic [aw:0]   rd_ptr,
   output logic [aw:0]   level,
   output logic          empty,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_data,
   output logic          out_last
);
   localparam int unsigned NB = dw / 8;
   localparam int unsigned PW = aw + 1;
   localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [BW-1:0] BI_LAST = BW'(NB - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        r_state, w_state_n;
   logic [PW-1:0] r_rd_ptr, w_rd_ptr_n;
   logic [dw-1:0] r_shreg, w_shreg_n;
   logic [BW-1:0] r_bi, w_bi_n;
   logic          w_empty;
   logic          w_load;

   assign w_empty = (wr_ptr == r_rd_ptr);

   // Next-state: flush overrides everything; a word load releases its RAM slot.
   always_comb begin
      w_state_n  = r_state;
      w_rd_ptr_n = r_rd_ptr;
      w_shreg_n  = r_shreg;
      w_bi_n     = r_bi;
      w_load     = 1'b0;
      if (flush) begin
         w_state_n  = IDLE;
         w_rd_ptr_n = wr_ptr;
         w_bi_n     = '0;
      end else begin
         case (r_state)
            IDLE: w_load = !w_empty;
            SHIFT: begin
               if (out_ready) begin
                  if (r_bi != BI_LAST) begin
                     w_shreg_n = r_shreg >> 8;
                     w_bi_n    = r_bi + BW'(1);
                  end else if (!w_empty) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_n = IDLE;
                  end
               end
            end
            default: w_state_n = IDLE;
         endcase
         if (w_load) begin
            w_shreg_n  = dout;
            w_rd_ptr_n = r_rd_ptr + PW'(1);
            w_bi_n     = '0;
            w_state_n  = SHIFT;
         end
      end
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_state  <= IDLE;
         r_rd_ptr <= '0;
         r_shreg  <= '0;
         r_bi     <= '0;
      end else begin
         r_state  <= w_state_n;
         r_rd_ptr <= w_rd_ptr_n;
         r_shreg  <= w_shreg_n;
         r_bi     <= w_bi_n;
      end
   end

   assign raddr     = r_rd_ptr[aw-1:0];
   assign rd_ptr    = r_rd_ptr;
   assign level     = wr_ptr - r_rd_ptr;
   assign empty     = w_empty;
   assign out_valid = (r_state == SHIFT);
   assign out_data  = r_shreg[7:0];
   assign out_last  = (r_state == SHIFT) && (r_bi == BI_LAST);

endmodule

// File: tb/tb_dpram_byte_reader.sv
// Bench for dpram_byte_reader: RAM + writer model, expected byte stream kept as a queue.
`timescale 1ns/1ps
module tb_dpram_byte_reader;
   logic        rclk = 1'b0;
   logic        rrst;
   logic [4:0]  wr_ptr;
   logic [3:0]  raddr;
   logic [31:0] dout;
   logic        flush;
   logic [4:0]  rd_ptr;
   logic [4:0]  level;
   logic        empty;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;

   logic [31:0] mem [16];
   logic [8:0]  exp_q [$];
   int          n_checks = 0;
   int          n_fail = 0;
   bit          saw_ptr_wrap = 0;
   bit          saw_addr_wrap = 0;

   always #5 rclk = ~rclk;
   assign dout = mem[raddr];

   dpram_byte_reader #(.aw(4), .dw(32)) dut (
      .rclk(rclk), .rrst(rrst), .wr_ptr(wr_ptr), .raddr(raddr), .dout(dout),
      .flush(flush), .rd_ptr(rd_ptr), .level(level), .empty(empty),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Writer: store word, bump pointer, expect its bytes little-endian.
   task automatic write_word(input logic [31:0] d);
      mem[wr_ptr[3:0]] = d;
      wr_ptr = wr_ptr + 5'd1;
      for (int k = 0; k < 4; k++)
         exp_q.push_back({1'(k == 3), 8'(d >> (8 * k))});
   endtask

   function automatic bit has_space();
      return 5'(wr_ptr - rd_ptr) < 5'd16;
   endfunction

   // One clock: score the handshake before the edge, check invariants after it.
   task automatic tick();
      logic [8:0] e;
      bit         stall;
      logic [7:0] pd;
      logic       pl;
      logic [4:0] prd;
      logic [3:0] pra;
      if (!rrst && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL extra_byte: observed=%0h expected=none", out_data);
         end else begin
            e = exp_q.pop_front();
            chk("byte_data", 64'(out_data), 64'(e[7:0]));
            chk("byte_last", 64'(out_last), 64'(e[8]));
         end
      end
      stall = !rrst && !flush && out_valid && !out_ready;
      pd = out_data; pl = out_last; prd = rd_ptr; pra = raddr;
      @(posedge rclk);
      #1;
      if (stall) begin
         chk("stall_valid", 64'(out_valid), 64'(1));
         chk("stall_data", 64'(out_data), 64'(pd));
         chk("stall_last", 64'(out_last), 64'(pl));
      end
      if (prd == 5'd31 && rd_ptr == 5'd0) saw_ptr_wrap = 1;
      if (pra == 4'd15 && raddr == 4'd0) saw_addr_wrap = 1;
      chk("empty_eq", 64'(empty), 64'(wr_ptr == rd_ptr));
      chk("level_eq", 64'(level), 64'(5'(wr_ptr - rd_ptr)));
      chk("raddr_eq", 64'(raddr), 64'(rd_ptr[3:0]));
      chk("level_bound", 64'(level <= 5'd16), 64'(1));
   endtask

   task automatic drain(input int ready_pct, input int max_cycles);
      int c = 0;
      while ((exp_q.size() != 0 || out_valid) && c < max_cycles) begin
         out_ready = ($urandom_range(99) < ready_pct);
         tick();
         c++;
      end
      chk("drain_done", 64'(exp_q.size() != 0 || out_valid), 64'(0));
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int sent;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      rrst = 1'b1; wr_ptr = '0; flush = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rrst = 1'b0;
      tick();
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_data", 64'(out_data), 64'(0));
      chk("rst_last", 64'(out_last), 64'(0));
      chk("rst_rdptr", 64'(rd_ptr), 64'(0));
      chk("rst_empty", 64'(empty), 64'(1));

      // Single word, latency and byte order
      out_ready = 1'b1;
      write_word(32'h44332211);
      #1;
      chk("t1_level", 64'(level), 64'(1));
      chk("t1_valid_pre", 64'(out_valid), 64'(0));
      tick();
      chk("t1_valid", 64'(out_valid), 64'(1));
      chk("t1_byte0", 64'(out_data), 64'(8'h11));
      chk("t1_last0", 64'(out_last), 64'(0));
      for (int i = 0; i < 4; i++) tick();
      chk("t1_idle", 64'(out_valid), 64'(0));
      chk("t1_rdptr", 64'(rd_ptr), 64'(1));
      chk("t1_q", 64'(exp_q.size()), 64'(0));

      // Three-word backlog streams without bubbles
      write_word($urandom); write_word($urandom); write_word($urandom);
      #1;
      chk("t2_level3", 64'(level), 64'(3));
      for (int c = 0; c < 12; c++) begin
         tick();
         chk("t2_valid", 64'(out_valid), 64'(1));
         chk("t2_level", 64'(level), 64'(2 - c / 4));
      end
      tick();
      chk("t2_idle", 64'(out_valid), 64'(0));
      chk("t2_empty", 64'(empty), 64'(1));

      // Random backpressure with a trickling writer
      sent = 0;
      for (int c = 0; c < 3000 && !(sent == 12 && exp_q.size() == 0 && !out_valid); c++) begin
         if (sent < 12 && has_space() && $urandom_range(2) == 0) begin
            write_word($urandom);
            sent++;
         end
         out_ready = $urandom_range(1) == 1;
         tick();
      end
      chk("t3_sent", 64'(sent), 64'(12));
      chk("t3_q", 64'(exp_q.size()), 64'(0));

      // 40 words through the 16-deep buffer, exercising both wraps
      sent = 0;
      for (int c = 0; c < 5000 && !(sent == 40 && exp_q.size() == 0 && !out_valid); c++) begin
         if (sent < 40 && has_space() && $urandom_range(1) == 1) begin
            write_word($urandom);
            sent++;
         end
         out_ready = $urandom_range(3) != 0;
         tick();
      end
      chk("t4_sent", 64'(sent), 64'(40));
      chk("t4_q", 64'(exp_q.size()), 64'(0));
      chk("t4_ptr_wrap", 64'(saw_ptr_wrap), 64'(1));
      chk("t4_addr_wrap", 64'(saw_addr_wrap), 64'(1));

      // Flush after two bytes of a four-word backlog
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) write_word($urandom);
      tick();
      chk("t5_valid", 64'(out_valid), 64'(1));
      out_ready = 1'b1;
      tick(); tick();
      flush = 1'b1;
      exp_q.delete();
      tick();
      flush = 1'b0;
      chk("t5_fl_valid", 64'(out_valid), 64'(0));
      chk("t5_fl_ptr", 64'(rd_ptr), 64'(wr_ptr));
      chk("t5_fl_level", 64'(level), 64'(0));
      chk("t5_fl_empty", 64'(empty), 64'(1));
      write_word(32'hA1B2C3D4);
      tick();
      chk("t5_new_valid", 64'(out_valid), 64'(1));
      chk("t5_new_byte0", 64'(out_data), 64'(8'hD4));
      drain(100, 20);

      // Reset while shifting
      out_ready = 1'b0;
      write_word($urandom); write_word($urandom);
      tick();
      chk("t6_shift", 64'(out_valid), 64'(1));
      rrst = 1'b1;
      wr_ptr = '0;
      exp_q.delete();
      tick();
      chk("t6_valid", 64'(out_valid), 64'(0));
      chk("t6_data", 64'(out_data), 64'(0));
      chk("t6_last", 64'(out_last), 64'(0));
      chk("t6_rdptr", 64'(rd_ptr), 64'(0));
      chk("t6_empty", 64'(empty), 64'(1));
      rrst = 1'b0;
      tick();
      chk("t6_idle", 64'(out_valid), 64'(0));
      write_word(32'hCAFEF00D);
      drain(60, 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
